// File: rtl/spi_sram_slave.sv
// spi_sram_slave: SPI mode-0 responder emulating a 23X256 serial SRAM
// (READ/WRITE/RDSR/WRSR); every pin is oversampled on clk.
module spi_sram_slave #(
   parameter int ADDR_W = 15,
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic arst_n,
   input  logic sck,
   input  logic cs_n,
   input  logic si,
   input  logic hold_n,
   output logic so,
   output logic so_oe
);
   typedef enum logic [2:0] {IDLE, CMD, ADDR, RDATA, WDATA, RDSR, WRSR, IGNORE} state_t;
   state_t state;
   logic [SYNC_STAGES-1:0] sck_q, cs_q, si_q, hold_q;
   logic sck_d, rise, fall, cs_s, si_s, hold_act, last, byte_mode, we, rd, ad_hi, oe_r, so_r;
   logic [2:0] bitcnt;
   logic [6:0] shreg;
   logic [7:0] sr, rd_q, d;
   logic [ADDR_W-1:0] addr, addr_nx;
   logic [7:0] mem [2**ADDR_W];
   always_ff @(posedge clk or negedge arst_n)
      if (!arst_n) begin
         sck_q <= '0;
         cs_q <= '1;
         si_q <= '0;
         hold_q <= '1;
         sck_d <= 1'b0;
      end else begin
         sck_q <= {sck_q[SYNC_STAGES-2:0], sck};
         cs_q <= {cs_q[SYNC_STAGES-2:0], cs_n};
         si_q <= {si_q[SYNC_STAGES-2:0], si};
         hold_q <= {hold_q[SYNC_STAGES-2:0], hold_n};
         sck_d <= sck_q[SYNC_STAGES-1];
      end
   assign cs_s = cs_q[SYNC_STAGES-1];
   assign si_s = si_q[SYNC_STAGES-1];
   assign rise = sck_q[SYNC_STAGES-1] & ~sck_d;
   assign fall = ~sck_q[SYNC_STAGES-1] & sck_d;
   assign hold_act = ~hold_q[SYNC_STAGES-1] & ~sr[0];
   assign last = bitcnt == 3'd7;
   assign d = {shreg, si_s};
   assign byte_mode = sr[7] == sr[6];
   // page mode wraps within a 32-byte page, sequential wraps the whole array
   assign addr_nx = sr[7] ? {addr[ADDR_W-1:5], addr[4:0] + 5'd1} : addr + ADDR_W'(1);
   assign we = state == WDATA && rise && last && !cs_s && !hold_act;
   assign so_oe = oe_r & ~hold_act;
   assign so = so_oe ? so_r : 1'bz;
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= d;
      rd_q <= mem[addr];
   end
   always_ff @(posedge clk or negedge arst_n)
      if (!arst_n) begin
         state <= IDLE;
         sr <= '0;
         shreg <= '0;
         bitcnt <= '0;
         ad_hi <= 1'b0;
         rd <= 1'b0;
         addr <= '0;
         oe_r <= 1'b0;
         so_r <= 1'b0;
      end else if (cs_s) begin
         state <= IDLE;
         bitcnt <= '0;
         ad_hi <= 1'b0;
         oe_r <= 1'b0;
      end else if (!hold_act) begin
         if (state == IDLE) state <= CMD;
         if (rise && state != IDLE) begin
            shreg <= d[6:0];
            bitcnt <= bitcnt + 3'd1;
         end
         if (rise) case (state)
            CMD: if (last) begin
               rd <= d == 8'h03;
               state <= d == 8'h03 || d == 8'h02 ? ADDR : d == 8'h05 ? RDSR : d == 8'h01 ? WRSR : IGNORE;
            end
            ADDR: begin
               addr <= {addr[ADDR_W-2:0], si_s};
               if (last) ad_hi <= 1'b1;
               if (last && ad_hi) state <= rd ? RDATA : WDATA;
            end
            RDATA, WDATA: if (last) begin
               addr <= addr_nx;
               if (byte_mode) begin
                  state <= IGNORE;
                  oe_r <= 1'b0;
               end
            end
            WRSR: if (last) begin
               sr <= {d[7:6], 5'b0, d[0]};
               state <= IGNORE;
            end
            default: ;
         endcase
         if (fall && (state == RDATA || state == RDSR)) begin
            oe_r <= 1'b1;
            so_r <= state == RDATA ? rd_q[~bitcnt] : sr[~bitcnt];
         end
      end
endmodule
